// File: rtl/norm_pkg.sv
// norm_pkg: shared FSM states and default sizes for the normaliser.
package norm_pkg;
  localparam int WIDTH_D = 32;
  localparam int CNT_W_D = 5;
  localparam int STEP4 = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/norm_detect.sv
// norm_detect: normalised / 4-bit-step test on the top five bits of the working register.
module norm_detect (
  input  logic [4:0] w_top,
  input  logic       signed_mode,
  output logic       is_norm,
  output logic       can_step4
);
  assign is_norm = signed_mode ? (w_top[4] ^ w_top[3]) : w_top[4];
  assign can_step4 = !is_norm && (signed_mode ? (&w_top || ~|w_top) : ~|w_top[4:1]);
endmodule

// File: rtl/norm_shift_unit.sv
// norm_shift_unit: multi-cycle left normaliser (clz / cls); NORM_STEP4_EN enables 4-bit fast steps.
module norm_shift_unit
  import norm_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] norm_out,
  output logic [CNT_W-1:0] sh_amt_out,
  output logic             zero_flag
);
`ifdef NORM_STEP4_EN
  localparam bit STEP4_ON = 1'b1;
`else
  localparam bit STEP4_ON = 1'b0;
`endif
  state_t state, state_nx;
  logic [WIDTH-1:0] w;
  logic [CNT_W-1:0] cnt;
  logic mode, is_norm, can_step4, step4;
  norm_detect u_detect (
    .w_top(w[WIDTH-1 -: 5]),
    .signed_mode(mode),
    .is_norm(is_norm),
    .can_step4(can_step4)
  );
  assign step4 = STEP4_ON && can_step4;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (start ? ((operand == '0) ? DONE : SHIFT) : IDLE) :
               (state == SHIFT) ? (is_norm ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      w <= '0;
      cnt <= '0;
      mode <= 1'b0;
      norm_out <= '0;
      sh_amt_out <= '0;
      zero_flag <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        w <= operand;
        cnt <= '0;
        mode <= signed_mode;
        if (operand == '0) begin
          norm_out <= '0;
          sh_amt_out <= '0;
          zero_flag <= 1'b1;
        end
      end else if (state == SHIFT) begin
        if (is_norm) begin
          norm_out <= w;
          sh_amt_out <= cnt;
          zero_flag <= 1'b0;
        end else if (step4) begin
          w <= w << STEP4;
          cnt <= cnt + CNT_W'(STEP4);
        end else begin
          w <= w << 1;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_norm_shift_unit.sv
// tb_norm_shift_unit: randomized and directed checks of norm_shift_unit against a leading-bit-count model.
module tb_norm_shift_unit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_mode = 1'b0;
  logic [31:0] operand = '0;
  logic busy, done, zero_flag;
  logic [31:0] norm_out;
  logic [4:0] sh_amt_out;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  norm_shift_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .signed_mode(signed_mode),
    .operand(operand),
    .busy(busy),
    .done(done),
    .norm_out(norm_out),
    .sh_amt_out(sh_amt_out),
    .zero_flag(zero_flag)
  );
  function automatic void model(input logic sm, input logic [31:0] op, output logic [31:0] n,
                                output logic [4:0] s, output logic z, output int steps);
    int c;
    c = 0;
    z = (op == 0);
    if (!z && !sm) for (int i = 31; i >= 0 && !op[i]; i--) c++;
    if (!z && sm) for (int i = 30; i >= 0 && op[i] == op[31]; i--) c++;
    n = z ? 32'h0 : op << c;
    s = 5'(c);
`ifdef NORM_STEP4_EN
    steps = c / 4 + c % 4;
`else
    steps = c;
`endif
  endfunction
  task automatic run_op(input logic sm, input logic [31:0] op, output logic [31:0] n,
                        output logic [4:0] s, output logic z, output int lat, output int bc,
                        output logic idle_after);
    @(negedge clk);
    start = 1'b1;
    signed_mode = sm;
    operand = op;
    @(posedge clk);
    #1;
    start = 1'b0;
    signed_mode = 1'($urandom);
    operand = $urandom;
    bc = 0;
    for (lat = 0; lat < 200; lat++) begin
      if (busy) bc++;
      if (done) break;
      @(posedge clk);
      #1;
    end
    n = norm_out;
    s = sh_amt_out;
    z = zero_flag;
    @(posedge clk);
    #1;
    idle_after = !busy && !done;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, zero_flag, norm_out, sh_amt_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b z=%b n=%h s=%0d, want all 0",
               busy, done, zero_flag, norm_out, sh_amt_out);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_start: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask
  typedef struct {logic sm; logic [31:0] op; logic [31:0] n; logic [4:0] s;} dir_t;
  task automatic test_directed();
    dir_t tbl[8] = '{
      '{1'b0, 32'h0001_0000, 32'h8000_0000, 5'd15}, '{1'b0, 32'h0000_0001, 32'h8000_0000, 5'd31},
      '{1'b0, 32'h8000_0000, 32'h8000_0000, 5'd0},  '{1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0},
      '{1'b1, 32'h0000_0000, 32'h0000_0000, 5'd0},  '{1'b1, 32'hFFFF_8000, 32'h8000_0000, 5'd16},
      '{1'b1, 32'h0000_3FFF, 32'h7FFE_0000, 5'd17}, '{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 5'd31}};
    logic [31:0] n, mn;
    logic [4:0] s, ms;
    logic z, mz, ia;
    int lat, bc, steps;
    foreach (tbl[i]) begin
      model(tbl[i].sm, tbl[i].op, mn, ms, mz, steps);
      run_op(tbl[i].sm, tbl[i].op, n, s, z, lat, bc, ia);
      vectors++;
      if (n !== tbl[i].n || s !== tbl[i].s || z !== (tbl[i].op == 0)) begin
        miscompares++;
        $display("FAIL dir_result[%0d] op=%h sm=%b: got n=%h s=%0d z=%b, want n=%h s=%0d z=%b",
                 i, tbl[i].op, tbl[i].sm, n, s, z, tbl[i].n, tbl[i].s, tbl[i].op == 0);
      end
      vectors++;
      if (lat !== ((tbl[i].op == 0) ? 0 : steps + 1) || bc !== ((tbl[i].op == 0) ? 1 : steps + 2) || !ia) begin
        miscompares++;
        $display("FAIL dir_timing[%0d] op=%h: got done_edge=%0d busy_cycles=%0d idle_after=%b, want %0d %0d 1",
                 i, tbl[i].op, lat, bc, ia, (tbl[i].op == 0) ? 0 : steps + 1, (tbl[i].op == 0) ? 1 : steps + 2);
      end
    end
  endtask
  task automatic test_random();
    logic [31:0] op, n, mn;
    logic [4:0] s, ms;
    logic z, mz, ia, sm;
    int lat, bc, steps;
    for (int i = 0; i < 60; i++) begin
      sm = 1'($urandom);
      op = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) op = 32'h0;
      if (sm && $urandom_range(0, 1) == 1) op = ~op;
      model(sm, op, mn, ms, mz, steps);
      run_op(sm, op, n, s, z, lat, bc, ia);
      vectors++;
      if (n !== mn || s !== ms || z !== mz) begin
        miscompares++;
        $display("FAIL rand_result op=%h sm=%b: got n=%h s=%0d z=%b, want n=%h s=%0d z=%b",
                 op, sm, n, s, z, mn, ms, mz);
      end
      vectors++;
      if (lat !== (mz ? 0 : steps + 1) || bc !== (mz ? 1 : steps + 2) || !ia) begin
        miscompares++;
        $display("FAIL rand_timing op=%h sm=%b: got done_edge=%0d busy_cycles=%0d idle_after=%b, want %0d %0d 1",
                 op, sm, lat, bc, ia, mz ? 0 : steps + 1, mz ? 1 : steps + 2);
      end
    end
  endtask
  task automatic test_busy_ignore();
    logic [31:0] mn;
    logic [4:0] ms;
    logic mz;
    int steps, lat;
    model(1'b0, 32'h0001_0000, mn, ms, mz, steps);
    @(negedge clk);
    start = 1'b1;
    signed_mode = 1'b0;
    operand = 32'h0001_0000;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    @(negedge clk);
    start = 1'b1;
    operand = 32'h0000_0001;
    signed_mode = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (lat = 1; lat < 200 && !done; lat++) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (norm_out !== mn || sh_amt_out !== ms || zero_flag !== 1'b0 || lat !== steps + 1) begin
      miscompares++;
      $display("FAIL busy_ignore: got n=%h s=%0d z=%b done_edge=%0d, want n=%h s=%0d z=0 done_edge=%0d",
               norm_out, sh_amt_out, zero_flag, lat, mn, ms, steps + 1);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ignore_idle: got busy=%b, want 0", busy);
    end
  endtask
  task automatic test_reset_mid();
    logic [31:0] n, mn;
    logic [4:0] s, ms;
    logic z, mz, ia;
    int lat, bc, steps;
    run_op(1'b0, 32'h0001_0000, n, s, z, lat, bc, ia);
    @(negedge clk);
    start = 1'b1;
    signed_mode = 1'b0;
    operand = 32'h0000_0001;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, zero_flag, norm_out, sh_amt_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b done=%b z=%b n=%h s=%0d, want all 0",
               busy, done, zero_flag, norm_out, sh_amt_out);
    end
    @(negedge clk) rst_n = 1'b1;
    model(1'b1, 32'h0000_3FFF, mn, ms, mz, steps);
    run_op(1'b1, 32'h0000_3FFF, n, s, z, lat, bc, ia);
    vectors++;
    if (n !== mn || s !== ms || z !== mz || lat !== steps + 1 || !ia) begin
      miscompares++;
      $display("FAIL after_reset: got n=%h s=%0d z=%b done_edge=%0d idle_after=%b, want n=%h s=%0d z=%b done_edge=%0d 1",
               n, s, z, lat, ia, mn, ms, mz, steps + 1);
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
